// File: rtl/biquad_band_scheduler_if.sv
// Engine-side bus of the band scheduler: operands and start pulse out to the
// shared double-biquad engine, result and valid back from it.
// master = scheduler side, slave = engine side.
interface biquad_band_scheduler_if #(
  parameter int BW = 32,
  parameter int IW = 3
);
  logic [IW-1:0]        coeff_idx_out;
  logic                 bq_valid_out;
  logic signed [BW-1:0] bq_x_n_out;
  logic signed [BW-1:0] bq_x_n1_out;
  logic signed [BW-1:0] bq_x_n2_out;
  logic signed [BW-1:0] bq_i_n1_out;
  logic signed [BW-1:0] bq_i_n2_out;
  logic signed [BW-1:0] bq_y_n1_out;
  logic signed [BW-1:0] bq_y_n2_out;
  logic                 bq_valid_in;
  logic signed [BW-1:0] bq_i_n_in;
  logic signed [BW-1:0] bq_y_n_in;

  modport master (
    output coeff_idx_out, bq_valid_out, bq_x_n_out, bq_x_n1_out, bq_x_n2_out,
           bq_i_n1_out, bq_i_n2_out, bq_y_n1_out, bq_y_n2_out,
    input  bq_valid_in, bq_i_n_in, bq_y_n_in
  );

  modport slave (
    input  coeff_idx_out, bq_valid_out, bq_x_n_out, bq_x_n1_out, bq_x_n2_out,
           bq_i_n1_out, bq_i_n2_out, bq_y_n1_out, bq_y_n2_out,
    output bq_valid_in, bq_i_n_in, bq_y_n_in
  );
endinterface

// File: rtl/biquad_band_scheduler.sv
// biquad_band_scheduler: time-multiplexes one shared double-biquad engine
// across N_BANDS filter-bank bands. Each accepted sample is walked through
// bands 0..N_BANDS-1; per-band i/y history lives here, x history is shared.
// Optional feature macro: BQ_TIMEOUT_EN (engine response timeout).
// The engine result is registered on arrival, so a band costs
// ISSUE + (L+1) WAIT + EMIT = 3+L cycles for an engine latency of L.
module biquad_band_scheduler #(
  parameter int N_BANDS = 8,
  parameter int BW      = 32,
  parameter int TIMEOUT = 64,
  localparam int IW     = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 valid_in,
  input  logic signed [BW-1:0] sample_in,
  input  logic                 clear_err_in,
  output logic                 busy_out,
  output logic                 overrun_out,
  biquad_band_scheduler_if.master eng,
  output logic signed [BW-1:0] band_out,
  output logic [IW-1:0]        band_idx_out,
  output logic                 band_valid_out,
  output logic                 frame_done_out,
  output logic                 timeout_out
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;

  localparam logic [IW-1:0] LAST_BAND = IW'(N_BANDS - 1);

  state_t               state, state_nx;
  logic [IW-1:0]        band;
  logic signed [BW-1:0] x_cur, x1, x2;
  logic signed [BW-1:0] i1 [N_BANDS];
  logic signed [BW-1:0] i2 [N_BANDS];
  logic signed [BW-1:0] y1 [N_BANDS];
  logic signed [BW-1:0] y2 [N_BANDS];
  logic                 rsp_valid;
  logic signed [BW-1:0] rsp_i, rsp_y;
  logic                 timed_out;
  logic                 operands_on;

`ifdef BQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Count WAIT cycles without an engine result; restarts on every new WAIT.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)          wait_cnt <= '0;
    else if (state != WAIT) wait_cnt <= '0;
    else if (!rsp_valid)    wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT) && !rsp_valid && (wait_cnt == CW'(TIMEOUT - 1));

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)         timeout_out <= 1'b0;
    else if (timed_out)    timeout_out <= 1'b1;
    else if (clear_err_in) timeout_out <= 1'b0;
  end
`else
  assign timed_out   = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // Capture the engine result; only a response arriving during WAIT counts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rsp_valid <= 1'b0;
      rsp_i     <= '0;
      rsp_y     <= '0;
    end else begin
      rsp_valid <= (state == WAIT) && eng.bq_valid_in;
      if (eng.bq_valid_in) begin
        rsp_i <= eng.bq_i_n_in;
        rsp_y <= eng.bq_y_n_in;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nx;
  end

  // Next state plus state-decoded strobes and engine operands.
  always_comb begin
    state_nx          = state;
    busy_out          = (state != IDLE);
    band_valid_out    = (state == EMIT);
    frame_done_out    = (state == DONE);
    operands_on       = (state == ISSUE) || (state == WAIT);
    eng.bq_valid_out  = (state == ISSUE);
    eng.coeff_idx_out = '0;
    eng.bq_x_n_out    = '0;
    eng.bq_x_n1_out   = '0;
    eng.bq_x_n2_out   = '0;
    eng.bq_i_n1_out   = '0;
    eng.bq_i_n2_out   = '0;
    eng.bq_y_n1_out   = '0;
    eng.bq_y_n2_out   = '0;
    if (operands_on) begin
      eng.coeff_idx_out = band;
      eng.bq_x_n_out    = x_cur;
      eng.bq_x_n1_out   = x1;
      eng.bq_x_n2_out   = x2;
      eng.bq_i_n1_out   = i1[band];
      eng.bq_i_n2_out   = i2[band];
      eng.bq_y_n1_out   = y1[band];
      eng.bq_y_n2_out   = y2[band];
    end
    unique case (state)
      IDLE:    if (valid_in) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (rsp_valid || timed_out) state_nx = EMIT;
      EMIT:    state_nx = (band == LAST_BAND) ? DONE : ISSUE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sample latch, band walk, per-band write-back and shared x history shift.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      band         <= '0;
      x_cur        <= '0;
      x1           <= '0;
      x2           <= '0;
      band_out     <= '0;
      band_idx_out <= '0;
      for (int b = 0; b < N_BANDS; b++) begin
        i1[b] <= '0;
        i2[b] <= '0;
        y1[b] <= '0;
        y2[b] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            x_cur <= sample_in;
            band  <= '0;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            i1[band]     <= rsp_i;
            i2[band]     <= i1[band];
            y1[band]     <= rsp_y;
            y2[band]     <= y1[band];
            band_out     <= rsp_y;
            band_idx_out <= band;
          end else if (timed_out) begin
            band_out     <= '0;
            band_idx_out <= band;
          end
        end
        EMIT: begin
          if (band != LAST_BAND) band <= band + 1'b1;
        end
        DONE: begin
          x2 <= x1;
          x1 <= x_cur;
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun: a sample offered while busy is dropped; set beats clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                      overrun_out <= 1'b0;
    else if (valid_in && state != IDLE) overrun_out <= 1'b1;
    else if (clear_err_in)              overrun_out <= 1'b0;
  end

endmodule

// File: tb/tb_biquad_band_scheduler.sv
// Self-checking bench for biquad_band_scheduler: a reference model pushes the
// expected band outputs and engine operands into queues when a sample is
// driven; monitors pop and compare when the DUT emits. A second instance
// with N_BANDS=1 covers the single-band frame. Timeout scenario is built
// only when BQ_TIMEOUT_EN is defined.
module tb_biquad_band_scheduler;
  localparam int BW = 32;
  localparam int NB = 8;
  localparam int IW = 3;
  localparam int L  = 2;
  localparam int TO = 64;
  localparam int FRAME_LAT = NB * (3 + L) + 1;

  typedef struct {
    int                   idx;
    logic signed [BW-1:0] val;
  } band_exp_t;

  typedef struct {
    int                   idx;
    logic signed [BW-1:0] x, x1, x2, y1, y2;
  } op_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // main DUT (N_BANDS=8)
  logic                 valid_in = 1'b0;
  logic signed [BW-1:0] sample_in = '0;
  logic                 clear_err = 1'b0;
  logic                 busy, overrun, band_valid, frame_done, timeout;
  logic signed [BW-1:0] band_out;
  logic [IW-1:0]        band_idx;
  biquad_band_scheduler_if #(.BW(BW), .IW(IW)) eng ();

  biquad_band_scheduler #(.N_BANDS(NB), .BW(BW), .TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .sample_in(sample_in),
    .clear_err_in(clear_err), .busy_out(busy), .overrun_out(overrun), .eng(eng),
    .band_out(band_out), .band_idx_out(band_idx), .band_valid_out(band_valid),
    .frame_done_out(frame_done), .timeout_out(timeout)
  );

  // single-band DUT
  logic                 valid1 = 1'b0;
  logic signed [BW-1:0] sample1 = '0;
  logic                 busy1, overrun1, bvalid1, done1, tmo1;
  logic signed [BW-1:0] band1;
  logic [0:0]           bidx1;
  biquad_band_scheduler_if #(.BW(BW), .IW(1)) eng1 ();

  biquad_band_scheduler #(.N_BANDS(1), .BW(BW), .TIMEOUT(TO)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid1), .sample_in(sample1),
    .clear_err_in(1'b0), .busy_out(busy1), .overrun_out(overrun1), .eng(eng1),
    .band_out(band1), .band_idx_out(bidx1), .band_valid_out(bvalid1),
    .frame_done_out(done1), .timeout_out(tmo1)
  );

  // engine models: fixed latency L from start pulse to result valid
  logic                 eng_mode = 1'b0;
  logic                 mute_on = 1'b0;
  logic                 late_pulse = 1'b0;
  logic [L:1]           evld, e1vld;
  logic signed [BW-1:0] ey [1:L];
  logic signed [BW-1:0] e1y [1:L];

  // Main engine: mode 0 y=i=x_n+x_n1, mode 1 y=i=x_n+y_n1; band 4 can be muted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evld <= '0;
      for (int k = 1; k <= L; k++) ey[k] <= '0;
    end else begin
      evld[1] <= eng.bq_valid_out && !(mute_on && eng.coeff_idx_out == 3'd4);
      ey[1]   <= eng_mode ? eng.bq_x_n_out + eng.bq_y_n1_out
                          : eng.bq_x_n_out + eng.bq_x_n1_out;
      for (int k = 2; k <= L; k++) begin
        evld[k] <= evld[k-1];
        ey[k]   <= ey[k-1];
      end
    end
  end
  assign eng.bq_valid_in = evld[L] | late_pulse;
  assign eng.bq_y_n_in   = ey[L];
  assign eng.bq_i_n_in   = ey[L];

  // Single-band engine: y=i=x_n+x_n1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1vld <= '0;
      for (int k = 1; k <= L; k++) e1y[k] <= '0;
    end else begin
      e1vld[1] <= eng1.bq_valid_out;
      e1y[1]   <= eng1.bq_x_n_out + eng1.bq_x_n1_out;
      for (int k = 2; k <= L; k++) begin
        e1vld[k] <= e1vld[k-1];
        e1y[k]   <= e1y[k-1];
      end
    end
  end
  assign eng1.bq_valid_in = e1vld[L];
  assign eng1.bq_y_n_in   = e1y[L];
  assign eng1.bq_i_n_in   = e1y[L];

  // scoreboard and reference model state
  band_exp_t            band_q[$];
  op_exp_t              op_q[$];
  logic signed [BW-1:0] m_x1, m_x2;
  logic signed [BW-1:0] m_y1 [NB];
  logic signed [BW-1:0] m_y2 [NB];
  int  checks = 0;
  int  errors = 0;
  int  cycle_count = 0;
  int  accept_cycle = 0;
  int  last_band_cycle = 0;
  int  last_gap = 0;
  int  done_cycle = 0;
  bit  spacing_on = 1'b0;
  band_exp_t be;
  op_exp_t   oe;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Free-running cycle counter used for latency and spacing measurements.
  always @(posedge clk) cycle_count++;

  // Output monitor: band strobes, engine operands and frame completion.
  always @(negedge clk) begin
    if (rst_n && band_valid) begin
      last_gap        = cycle_count - last_band_cycle;
      last_band_cycle = cycle_count;
      checkOutput("band_expected_pending", band_q.size() > 0, 1);
      if (band_q.size() > 0) begin
        be = band_q.pop_front();
        checkOutput("band_idx", band_idx, be.idx);
        checkOutput("band_out", band_out, be.val);
      end
      if (spacing_on && band_idx != 0) checkOutput("band_spacing", last_gap, 3 + L);
    end
    if (rst_n && eng.bq_valid_out) begin
      checkOutput("op_expected_pending", op_q.size() > 0, 1);
      if (op_q.size() > 0) begin
        oe = op_q.pop_front();
        checkOutput("op_coeff_idx", eng.coeff_idx_out, oe.idx);
        checkOutput("op_x_n", eng.bq_x_n_out, oe.x);
        checkOutput("op_x_n1", eng.bq_x_n1_out, oe.x1);
        checkOutput("op_x_n2", eng.bq_x_n2_out, oe.x2);
        checkOutput("op_y_n1", eng.bq_y_n1_out, oe.y1);
        checkOutput("op_y_n2", eng.bq_y_n2_out, oe.y2);
        checkOutput("op_i_n1", eng.bq_i_n1_out, oe.y1);
        checkOutput("op_i_n2", eng.bq_i_n2_out, oe.y2);
      end
    end
    if (rst_n && frame_done) begin
      checkOutput("done_after_last_band", cycle_count - last_band_cycle, 1);
      done_cycle = cycle_count;
    end
  end

  task automatic resetModel();
    m_x1 = '0;
    m_x2 = '0;
    for (int b = 0; b < NB; b++) begin
      m_y1[b] = '0;
      m_y2[b] = '0;
    end
    band_q.delete();
    op_q.delete();
  endtask

  task automatic checkResetState(input string p);
    checkOutput({p, "_busy"}, busy, 0);
    checkOutput({p, "_overrun"}, overrun, 0);
    checkOutput({p, "_timeout"}, timeout, 0);
    checkOutput({p, "_band_valid"}, band_valid, 0);
    checkOutput({p, "_frame_done"}, frame_done, 0);
    checkOutput({p, "_band_out"}, band_out, 0);
    checkOutput({p, "_band_idx"}, band_idx, 0);
    checkOutput({p, "_bq_valid"}, eng.bq_valid_out, 0);
    checkOutput({p, "_coeff_idx"}, eng.coeff_idx_out, 0);
    checkOutput({p, "_x_n"}, eng.bq_x_n_out, 0);
    checkOutput({p, "_y_n1"}, eng.bq_y_n1_out, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one sample when idle and queue the expected operands/outputs.
  task automatic applyStimulus(input logic signed [BW-1:0] s);
    int n = 0;
    logic signed [BW-1:0] y;
    op_exp_t   o;
    band_exp_t e;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_before_sample", busy, 0);
    for (int b = 0; b < NB; b++) begin
      o.idx = b; o.x = s; o.x1 = m_x1; o.x2 = m_x2; o.y1 = m_y1[b]; o.y2 = m_y2[b];
      op_q.push_back(o);
      if (mute_on && b == 4) y = '0;
      else begin
        y = eng_mode ? s + m_y1[b] : s + m_x1;
        m_y2[b] = m_y1[b];
        m_y1[b] = y;
      end
      e.idx = b; e.val = y;
      band_q.push_back(e);
    end
    m_x2 = m_x1;
    m_x1 = s;
    valid_in     = 1'b1;
    sample_in    = s;
    accept_cycle = cycle_count;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic waitFrame(input int max_cycles, input int exp_lat);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
      if (frame_done) seen = 1'b1;
    end
    checkOutput("frame_done_seen", seen, 1);
    if (seen && exp_lat >= 0) checkOutput("frame_latency", done_cycle - accept_cycle, exp_lat);
    checkOutput("band_queue_drained", band_q.size(), 0);
    checkOutput("op_queue_drained", op_q.size(), 0);
  endtask

  // Return one negedge into WAIT of the given band.
  task automatic waitIssue(input int idx);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      if (eng.bq_valid_out && eng.coeff_idx_out == idx) seen = 1'b1;
    end
    checkOutput("issue_seen", seen, 1);
    @(negedge clk);
  endtask

  task automatic singleBandFrame(input logic signed [BW-1:0] s, input int exp_val);
    int start;
    int n = 0;
    @(negedge clk);
    valid1  = 1'b1;
    sample1 = s;
    start   = cycle_count;
    @(negedge clk);
    valid1 = 1'b0;
    while (!bvalid1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("nb1_band_valid", bvalid1, 1);
    checkOutput("nb1_band_out", band1, exp_val);
    checkOutput("nb1_band_idx", bidx1, 0);
    checkOutput("nb1_band_latency", cycle_count - start, 3 + L);
    @(negedge clk);
    checkOutput("nb1_frame_done", done1, 1);
    checkOutput("nb1_frame_latency", cycle_count - start, 4 + L);
    checkOutput("nb1_single_strobe", bvalid1, 0);
  endtask

  initial begin
    resetModel();
    #2 rst_n = 1'b0;
    #1 checkResetState("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // abort a frame with reset while waiting on band 3
    eng_mode = 1'b0;
    applyStimulus(9);
    waitIssue(3);
    #2 rst_n = 1'b0;
    #1 checkResetState("midwait");
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // shared x history: 5 then 7 -> 5s then 12s
    spacing_on = 1'b1;
    applyStimulus(5);
    waitFrame(200, FRAME_LAT);
    applyStimulus(7);
    waitFrame(200, FRAME_LAT);
    spacing_on = 1'b0;

    // per-band y write-back: three ones -> 1, 2, 3
    pulseReset();
    eng_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      waitFrame(200, FRAME_LAT);
    end

    // overrun during WAIT of band 2
    eng_mode = 1'b0;
    applyStimulus(3);
    waitIssue(2);
    valid_in  = 1'b1;
    sample_in = 99;
    @(negedge clk);
    valid_in = 1'b0;
    #1 checkOutput("overrun_set", overrun, 1);
    waitFrame(200, FRAME_LAT);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    #1 checkOutput("overrun_cleared", overrun, 0);
    applyStimulus(6);
    waitIssue(2);
    valid_in  = 1'b1;
    clear_err = 1'b1;
    @(negedge clk);
    valid_in  = 1'b0;
    clear_err = 1'b0;
    #1 checkOutput("overrun_set_beats_clear", overrun, 1);
    waitFrame(200, FRAME_LAT);
    checkOutput("overrun_sticky", overrun, 1);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;

    // single-band instance: x history 0 then 4
    singleBandFrame(4, 4);
    singleBandFrame(6, 10);

`ifdef BQ_TIMEOUT_EN
    pulseReset();
    eng_mode = 1'b0;
    applyStimulus(2);
    waitFrame(300, FRAME_LAT);
    mute_on = 1'b1;
    applyStimulus(3);
    begin
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 500) begin
        @(negedge clk);
        #1;
        n++;
        if (band_valid && band_idx == 4) seen = 1'b1;
      end
      checkOutput("to_band4_seen", seen, 1);
      checkOutput("to_flag", timeout, 1);
      checkOutput("to_gap", last_gap, TO + 2);
      late_pulse = 1'b1;
      @(negedge clk);
      late_pulse = 1'b0;
    end
    waitFrame(600, FRAME_LAT + TO - (L + 1));
    mute_on = 1'b0;
    checkOutput("to_sticky", timeout, 1);
    applyStimulus(4);
    waitFrame(300, FRAME_LAT);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    #1 checkOutput("to_cleared", timeout, 0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/biquad_band_scheduler.md
Name: biquad_band_scheduler

Overview:
- Time-multiplexes one shared double-biquad engine across N_BANDS filter-bank bands. This is the sequencer that turns a single engine into a full analysis filter bank.
- For each accepted modulator sample, it walks bands 0..N_BANDS-1 in order. For each band it:
  - drives that band's coefficient-set index and stored history into the engine;
  - waits for the engine result;
  - writes back the band state;
  - emits the band output.
- Sits between the sample source and the envelope stage. The coefficient ROM and the engine live outside this block.

Parameters:
- N_BANDS, 8, number of bands (1..16); band b uses coefficient set b.
- BW, 32, sample and state word width (signed).
- TIMEOUT, 64, cycles to wait for an engine response (used only with BQ_TIMEOUT_EN).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- valid_in  in  1  new sample strobe; accepted only in IDLE.
- sample_in  in  BW  signed modulator sample.
- clear_err_in  in  1  clears overrun_out and timeout_out.
- busy_out  out  1  high whenever state != IDLE.
- overrun_out  out  1  sticky; set when valid_in arrives while busy.
- coeff_idx_out  out  $clog2(N_BANDS) (min 1)  coefficient-set select for the engine.
- bq_valid_out  out  1  one-cycle start pulse to the engine.
- bq_x_n_out, bq_x_n1_out, bq_x_n2_out  out  BW each  input history.
- bq_i_n1_out, bq_i_n2_out  out  BW each  intermediate history of the current band.
- bq_y_n1_out, bq_y_n2_out  out  BW each  output history of the current band.
- bq_valid_in  in  1  engine result valid.
- bq_i_n_in, bq_y_n_in  in  BW each  engine intermediate and output.
- band_out  out  BW  filtered band sample.
- band_idx_out  out  $clog2(N_BANDS)  band index of band_out.
- band_valid_out  out  1  one-cycle strobe.
- frame_done_out  out  1  one-cycle strobe after the last band.
- timeout_out  out  1  sticky engine timeout flag (BQ_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_n_in low):
  - state=IDLE; band counter=0.
  - All per-band history (i1,i2,y1,y2 per band) and shared x1,x2 cleared to 0.
  - Every output is 0, including sticky flags.
  - Reset mid-frame aborts the frame: no band_valid_out, no frame_done_out.
- FSM states: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - On valid_in, latch x_cur=sample_in, set band=0, go to ISSUE.
- ISSUE (1 cycle):
  - Drive coeff_idx_out=band; bq_x_n_out=x_cur; bq_x_n1/x_n2=shared x1/x2; i/y history from state[band].
  - Pulse bq_valid_out; go to WAIT.
  - Operand outputs hold stable from ISSUE until leaving WAIT.
- WAIT:
  - On bq_valid_in, write state[band]: i1<=bq_i_n_in, i2<=old i1, y1<=bq_y_n_in, y2<=old y1.
  - Register band_out=bq_y_n_in and band_idx_out=band; go to EMIT.
  - bq_valid_in in any other state is ignored.
- EMIT (1 cycle):
  - band_valid_out=1.
  - If band==N_BANDS-1, go to DONE; else band++ and go to ISSUE.
- DONE (1 cycle):
  - frame_done_out=1; shift shared history x2<=x1, x1<=x_cur; go to IDLE.
- Latency:
  - Per band: 3 + L cycles, where L is the engine latency from bq_valid_out to bq_valid_in (L>=1).
  - Per frame: N_BANDS*(3+L)+1 cycles from acceptance to frame_done_out.
- Overrun:
  - valid_in in any non-IDLE state (including DONE) is dropped and sets overrun_out.
  - The frame in progress is unaffected.
- Sticky flags:
  - clear_err_in clears both sticky flags.
  - If clear_err_in and a set event occur in the same cycle, set wins.
- band_out and band_idx_out hold their last value between strobes.
- N_BANDS=1: band never increments; EMIT goes straight to DONE.

Optional Feature:
- Macro BQ_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT. If TIMEOUT cycles pass without bq_valid_in, the block sets timeout_out.
  - It emits band_out=0 for that band and leaves state[band] unchanged, then proceeds to EMIT as normal.
  - A late bq_valid_in after the timeout is ignored.
- When undefined: WAIT lasts indefinitely; timeout_out is tied 0; no counter logic.

Test Plan:
- Reset values: reset asserted mid-WAIT with band=3 -> all outputs 0 immediately (async); after release, valid_in starts at band 0 with zeroed history.
- Engine model y=i=x_n+x_n1, L=2, N_BANDS=8, samples 5 then 7:
  - first frame emits band_out=5 for indices 0..7 with band_valid_out spaced 5 cycles apart, then frame_done_out;
  - second frame emits 12 for every band.
- History write-back: engine model y=x_n+y_n1, three samples of 1 -> every band outputs 1, 2, 3.
- Operand check: on the third sample, each band's bq_y_n1_out/bq_y_n2_out equal that band's previous two outputs.
- Overrun: valid_in pulsed during WAIT of band 2 -> overrun_out=1, frame completes all 8 bands; clear_err_in -> 0; clear and overrun in the same cycle -> stays 1.
- N_BANDS=1 build: one band_valid_out with idx 0, frame_done_out on the next cycle, total latency 3+L+1.
- BQ_TIMEOUT_EN, TIMEOUT=64: engine silent for band 4 ->
  - 64 cycles into WAIT: timeout_out=1, band_out=0 for idx 4;
  - bands 5..7 continue normally;
  - a late bq_valid_in is ignored;
  - the next frame's band 4 operands equal the pre-timeout history.
